// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM state encoding for the UART command sequencer.
package uart_cmd_pkg;

    // Protocol bytes
    localparam logic [7:0] SOF    = 8'hA5;
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        EXEC,
        SEND1,
        WAIT1,
        SEND2,
        WAIT2
    } state_t;

    // True while a frame is being assembled and the inter-byte gap matters.
    function automatic logic is_get_state(input state_t s);
        return (s == GET_CMD) || (s == GET_ADDR) || (s == GET_DATA) || (s == GET_CHK);
    endfunction

endpackage

// File: rtl/cmd_gap_timer.sv
// Saturating idle-gap timer: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES-1 is reached. Usable by any framed receiver.
module cmd_gap_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Gap counter: clear wins, otherwise count while enabled and hold at LAST.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frame-level command controller: assembles SOF/CMD/ADDR/DATA/CHK frames from
// the UART receiver, executes register reads/writes and returns ACK/NAK (plus
// read data) to the UART transmitter over a start/busy handshake.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ       = 50000000,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int NUM_REGS       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       reg_wr_en,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] reg_rd_data,
    output logic       frame_err,
    output logic       busy
);

    // The register address port is 4 bits, so at most 16 registers exist.
    if (NUM_REGS < 1 || NUM_REGS > 16 || CLK_FREQ <= 0) begin : g_bad_params
        $error("uart_cmd_sequencer: unsupported parameter values");
    end

    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    state_t     state, state_nxt;
    logic       rx_valid_d;
    logic       byte_accept;
    logic       in_get;
    logic       gap_expired;
    logic [7:0] cmd_q;
    logic [7:0] addr_q;
    logic       frame_ok;
    logic       is_rd;
    logic [7:0] resp_data;
    logic       frame_good;
    logic       tx_start_nxt;
    logic [7:0] tx_data_nxt;
    logic       wr_en_nxt;
    logic       err_nxt;

    // One byte per rising edge of the receiver's level-valid.
    assign byte_accept = rx_valid && !rx_valid_d;
    assign in_get      = is_get_state(state);
    assign busy        = (state != IDLE);

    // Frame check evaluated against the CHK byte as it arrives.
    assign frame_good = (rx_data == (cmd_q ^ addr_q ^ reg_wr_data))
                     && ((cmd_q == CMD_WR) || (cmd_q == CMD_RD))
                     && (addr_q < NUM_REGS_B);

    cmd_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (byte_accept || !in_get),
        .enable (in_get),
        .expired(gap_expired)
    );

    // Next-state and next-output decode.
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt    = state;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        wr_en_nxt    = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (byte_accept && (rx_data == SOF)) state_nxt = GET_CMD;
            end
            GET_CMD, GET_ADDR, GET_DATA: begin
                if (byte_accept) begin
                    state_nxt = (state == GET_CMD)  ? GET_ADDR :
                                (state == GET_ADDR) ? GET_DATA : GET_CHK;
                end else if (gap_expired) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            GET_CHK: begin
                if (byte_accept) begin
                    state_nxt = EXEC;
                    wr_en_nxt = frame_good && (cmd_q == CMD_WR);
                    err_nxt   = !frame_good;
                end else if (gap_expired) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            EXEC: begin
                // Request the first byte immediately when the transmitter is idle.
                state_nxt = SEND1;
                if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = frame_ok ? ACK : NAK;
                end
            end
            SEND1: begin
                if (tx_start) begin
                    state_nxt = WAIT1;
                end else if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = frame_ok ? ACK : NAK;
                end
            end
            WAIT1: begin
                if (!tx_busy) begin
                    if (frame_ok && is_rd) begin
                        state_nxt    = SEND2;
                        tx_start_nxt = 1'b1;
                        tx_data_nxt  = resp_data;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            SEND2: begin
                if (tx_start) begin
                    state_nxt = WAIT2;
                end else if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = resp_data;
                end
            end
            WAIT2: begin
                if (!tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            reg_wr_en <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_start  <= tx_start_nxt;
            tx_data   <= tx_data_nxt;
            reg_wr_en <= wr_en_nxt;
            frame_err <= err_nxt;
        end
    end

    // Frame field capture, validation flags and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid_d  <= 1'b0;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            reg_addr    <= 4'h0;
            reg_wr_data <= 8'h00;
            frame_ok    <= 1'b0;
            is_rd       <= 1'b0;
            resp_data   <= 8'h00;
        end else begin
            rx_valid_d <= rx_valid;
            if (byte_accept) begin
                case (state)
                    GET_CMD:  cmd_q <= rx_data;
                    GET_ADDR: begin
                        addr_q   <= rx_data;
                        reg_addr <= rx_data[3:0];
                    end
                    GET_DATA: reg_wr_data <= rx_data;
                    GET_CHK:  begin
                        frame_ok <= frame_good;
                        is_rd    <= (cmd_q == CMD_RD);
                    end
                    default: ;
                endcase
            end
            if ((state == EXEC) && frame_ok && is_rd) resp_data <= reg_rd_data;
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: directed test-plan frames plus
// randomized frames checked against a frame-level reference model.
module tb_uart_cmd_sequencer;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       reg_wr_en;
    logic [3:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_data;
    logic       frame_err;
    logic       busy;

    logic       tx_busy_model = 1'b0;
    logic       stall = 1'b0;
    int         tx_len = 4;

    logic [7:0] bank [16];   // environment register bank written by the DUT
    logic [7:0] mdl  [16];   // reference model's view of the registers

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;

    logic [11:0] wr_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    int          fall_q[$];
    int          err_cnt = 0;
    int          err_cyc = -1;
    int          wr_cyc  = -1;
    logic        prev_start = 1'b0;
    logic        prev_busy  = 1'b0;

    assign tx_busy     = tx_busy_model | stall;
    assign reg_rd_data = bank[reg_addr];

    always #5 clk = ~clk;

    uart_cmd_sequencer #(
        .CLK_FREQ      (50000000),
        .TIMEOUT_CYCLES(TO),
        .NUM_REGS      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .reg_wr_en  (reg_wr_en),
        .reg_addr   (reg_addr),
        .reg_wr_data(reg_wr_data),
        .reg_rd_data(reg_rd_data),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter: value equals the number of the most recent rising edge.
    always @(posedge clk) cyc++;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_wr_en === 1'b1) begin
                wr_q.push_back({reg_addr, reg_wr_data});
                wr_cyc = cyc;
                bank[reg_addr] = reg_wr_data;
            end
            if (frame_err === 1'b1) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (tx_start === 1'b1) begin
                tx_q.push_back(tx_data);
                tx_cyc_q.push_back(cyc);
                check("start_while_busy", {31'b0, tx_busy}, 0);
                check("start_back_to_back", {31'b0, prev_start}, 0);
            end
            if (prev_busy && !tx_busy) fall_q.push_back(cyc);
        end
        prev_start = tx_start;
        prev_busy  = tx_busy;
    end

    // Transmitter model: busy from the cycle after tx_start for tx_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                @(posedge clk);
                #1 tx_busy_model = 1'b1;
                repeat (tx_len) @(posedge clk);
                #1 tx_busy_model = 1'b0;
            end
        end
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish before 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_obs();
        wr_q.delete();
        tx_q.delete();
        tx_cyc_q.delete();
        fall_q.delete();
        err_cnt = 0;
        err_cyc = -1;
        wr_cyc  = -1;
    endtask

    // Called at a negedge; the byte is accepted at the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        last_acc = cyc;
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy !== 1'b0 || tx_busy !== 1'b0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'b0, (k < 5000)}, 1);
        repeat (2) @(negedge clk);
    endtask

    // Send one frame and compare against the frame-level model.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] data, input logic [7:0] chk,
                             input int gap, input string id);
        logic       ok;
        logic       is_wr;
        logic [7:0] exp_tx[$];
        int         t_chk;
        ok    = (chk == (cmd ^ addr ^ data)) && (cmd == 8'h57 || cmd == 8'h52) && (addr < 8'd16);
        is_wr = ok && (cmd == 8'h57);
        if (!ok) begin
            exp_tx.push_back(8'h15);
        end else begin
            exp_tx.push_back(8'h06);
            if (cmd == 8'h52) exp_tx.push_back(mdl[addr[3:0]]);
        end
        if (is_wr) mdl[addr[3:0]] = data;
        clear_obs();
        send_byte(8'hA5);
        repeat (gap) @(negedge clk);
        send_byte(cmd);
        repeat (gap) @(negedge clk);
        send_byte(addr);
        repeat (gap) @(negedge clk);
        send_byte(data);
        repeat (gap) @(negedge clk);
        send_byte(chk);
        t_chk = last_acc;
        wait_idle({id, "_done"});
        check({id, "_wr_count"}, wr_q.size(), is_wr ? 1 : 0);
        if (is_wr && wr_q.size() == 1) begin
            check({id, "_wr_addr_data"}, {20'b0, wr_q[0]}, {20'b0, addr[3:0], data});
            check({id, "_wr_cycle"}, wr_cyc, t_chk);
        end
        check({id, "_err_count"}, err_cnt, ok ? 0 : 1);
        if (!ok && err_cnt == 1) check({id, "_err_cycle"}, err_cyc, t_chk);
        check({id, "_tx_count"}, tx_q.size(), exp_tx.size());
        for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++)
            check($sformatf("%s_tx_byte%0d", id, i), {24'b0, tx_q[i]}, {24'b0, exp_tx[i]});
        if (tx_cyc_q.size() > 0) check({id, "_tx_first_cycle"}, tx_cyc_q[0], t_chk + 1);
        if (tx_cyc_q.size() == 2 && fall_q.size() > 0)
            check({id, "_tx_second_after_fall"}, {31'b0, (tx_cyc_q[1] > fall_q[0])}, 1);
    endtask

    initial begin
        logic [7:0] c, a, d, k;
        int         r;
        for (int i = 0; i < 16; i++) begin
            mdl[i]  = 8'($urandom);
            bank[i] = mdl[i];
        end

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_tx_data", {24'b0, tx_data}, 0);
        check("rst_tx_start", {31'b0, tx_start}, 0);
        check("rst_reg_wr_en", {31'b0, reg_wr_en}, 0);
        check("rst_reg_addr", {28'b0, reg_addr}, 0);
        check("rst_reg_wr_data", {24'b0, reg_wr_data}, 0);
        check("rst_frame_err", {31'b0, frame_err}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frames from the test plan.
        run_frame(8'h57, 8'h03, 8'h5C, 8'h08, 0, "write");
        tx_len = 6;
        run_frame(8'h52, 8'h03, 8'h00, 8'h51, 1, "read");
        run_frame(8'h57, 8'h03, 8'h5C, 8'h00, 0, "bad_chk");
        run_frame(8'h57, 8'h10, 8'h00, 8'h47, 0, "bad_addr");
        run_frame(8'h41, 8'h02, 8'h00, 8'h43, 0, "bad_cmd");
        run_frame(8'h52, 8'h0F, 8'h77, 8'h52 ^ 8'h0F ^ 8'h77, 2, "read_top");

        // Gap of exactly TIMEOUT_CYCLES between bytes is still accepted.
        run_frame(8'h57, 8'h0A, 8'hC3, 8'h57 ^ 8'h0A ^ 8'hC3, TO - 2, "gap_edge");

        // Timeout: next byte arrives one cycle too late; then a junk byte is ignored.
        clear_obs();
        send_byte(8'hA5);
        send_byte(8'h57);
        r = last_acc;
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h11);
        repeat (10) @(negedge clk);
        check("to_err_count", err_cnt, 1);
        check("to_err_cycle", err_cyc, r + TO);
        check("to_tx_count", tx_q.size(), 0);
        check("to_wr_count", wr_q.size(), 0);
        check("to_idle", {31'b0, busy}, 0);
        run_frame(8'h57, 8'h07, 8'h99, 8'h57 ^ 8'h07 ^ 8'h99, 0, "resync");

        // Handshake stall: transmitter held busy through EXEC.
        clear_obs();
        tx_len = 20;
        stall  = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'h3C);
        send_byte(8'h6E);
        mdl[5] = 8'h3C;
        repeat (200) @(negedge clk);
        check("stall_no_start", tx_q.size(), 0);
        check("stall_wr_count", wr_q.size(), 1);
        stall = 1'b0;
        @(negedge clk);
        check("stall_release_start", {31'b0, tx_start}, 1);
        check("stall_release_data", {24'b0, tx_data}, 8'h06);
        @(negedge clk);
        send_byte(8'hA5);            // lands in WAIT1 and must be dropped
        wait_idle("stall_done");
        repeat (10) @(negedge clk);
        check("stall_tx_count", tx_q.size(), 1);
        check("stall_dropped_byte", {31'b0, busy}, 0);
        check("stall_err_count", err_cnt, 0);

        // Reset in the middle of a frame.
        tx_len = 4;
        clear_obs();
        send_byte(8'hA5);
        send_byte(8'h57);
        send_byte(8'h03);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_reg_addr", {28'b0, reg_addr}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_outputs", {22'b0, tx_start, reg_wr_en, frame_err, tx_data},
              {22'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'h5C);
        send_byte(8'h08);
        repeat (5) @(negedge clk);
        check("mid_rst_no_write", wr_q.size(), 0);
        check("mid_rst_no_tx", tx_q.size(), 0);
        run_frame(8'h57, 8'h03, 8'h5C, 8'h08, 0, "post_rst");

        // Randomized frames.
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            c = (r < 4) ? 8'h57 : (r < 8) ? 8'h52 : 8'($urandom);
            a = 8'($urandom_range(0, 19));
            d = 8'($urandom);
            k = c ^ a ^ d;
            if ($urandom_range(0, 99) < 15) k = k ^ 8'($urandom_range(1, 255));
            tx_len = $urandom_range(1, 10);
            run_frame(c, a, d, k, $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Frame-level command controller between the UART receiver and the UART transmitter. Consumes received bytes, assembles 5-byte command frames, validates them, executes register reads/writes on a local register bank, and sequences the response bytes into the transmitter through a start/busy handshake. An inter-byte timeout discards partial frames.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz; documentation only.
- `TIMEOUT_CYCLES`, 50000: maximum idle gap between bytes of one frame, in clk cycles (1 ms at 50 MHz).
- `NUM_REGS`, 16: number of addressable registers; legal addresses are 0..NUM_REGS-1.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received byte; valid while `rx_valid` is high.
- `rx_valid` in 1: byte-ready level from the receiver. One byte is accepted per rising edge.
- `tx_data` out 8: byte to transmit; stable while `tx_start` is high.
- `tx_start` out 1: one-cycle transmit request.
- `tx_busy` in 1: transmitter busy. It must be high in the cycle after `tx_start` and stay high until the byte is sent.
- `reg_wr_en` out 1: one-cycle register write strobe.
- `reg_addr` out 4: register address, for reads and writes.
- `reg_wr_data` out 8: write data.
- `reg_rd_data` in 8: combinational read data for `reg_addr`.
- `frame_err` out 1: one-cycle pulse on checksum error, bad command, bad address, or timeout.
- `busy` out 1: high in every state except IDLE.

## Operation
- Frame format: SOF=0xA5, CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA.
- Commands: 0x57 ('W') is a write; 0x52 ('R') is a read. For a read, the DATA byte is don't-care but is still included in CHK.
- Byte accept: a byte is accepted when `rx_valid` is high and the `rx_valid_d` register is low. `rx_valid_d` resets to 0.
- States:
  - IDLE: an accepted byte equal to 0xA5 moves to GET_CMD. Any other byte is ignored with no error.
  - GET_CMD, GET_ADDR, GET_DATA, GET_CHK: each accepted byte is latched and the FSM advances.
  - After GET_CHK the FSM moves to EXEC.
- EXEC (exactly one cycle):
  - A frame is valid only if the checksum matches, CMD is 'W' or 'R', and ADDR < NUM_REGS.
  - Valid write: `reg_wr_en`=1 with the latched `reg_addr`/`reg_wr_data`. The response is ACK (0x06).
  - Valid read: `reg_rd_data` is captured into a response register. The response is ACK followed by the data byte.
  - Invalid frame: no write, `frame_err` pulses, and the response is NAK (0x15).
- Response states:
  - SEND1: waits for `tx_busy`=0, then drives `tx_start` for one cycle with the first byte and moves to WAIT1.
  - WAIT1: waits for `tx_busy`=0. It then goes to SEND2 for a valid read, otherwise to IDLE.
  - SEND2 and WAIT2: same as SEND1/WAIT1 with the read data byte, then go to IDLE.
- Bytes accepted during EXEC, SEND*, or WAIT* are dropped silently.
- Timeout:
  - The gap counter clears on every accepted byte and counts only in the GET_* states.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, `frame_err` pulses, and nothing is sent.
- Simultaneous events: an accepted byte in the same cycle as timeout expiry takes priority. The byte is processed and the counter clears.
- Reset mid-operation: the FSM returns to IDLE immediately and all outputs go low or zero. A partial frame never produces a write.
- Reset values: `tx_data`=0, `tx_start`=0, `reg_wr_en`=0, `reg_addr`=0, `reg_wr_data`=0, `frame_err`=0, `busy`=0.

## Timing
- Let T be the cycle in which the CHK byte is accepted.
  - T+1: EXEC. `reg_wr_en` and `frame_err` are high in this cycle.
  - T+2: earliest `tx_start`, if `tx_busy`=0.
- Second byte of a read: `tx_start` comes no earlier than 1 cycle after `tx_busy` falls following the first byte.
- `tx_start` is never asserted while `tx_busy`=1. `tx_start` is never high for two consecutive cycles.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- The gap counter is $clog2(TIMEOUT_CYCLES) bits wide. It saturates and never wraps.

## Structure
- Package `uart_cmd_pkg` holds:
  - Constants: SOF (0xA5), CMD_WR (0x57), CMD_RD (0x52), ACK (0x06), NAK (0x15).
  - The FSM state encoding: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, SEND1, WAIT1, SEND2, WAIT2.
- Sub-module `cmd_gap_timer`:
  - Parameter TIMEOUT_CYCLES.
  - Ports clk, reset, clear, enable, expired.
  - Reusable for other framed interfaces.

## Test plan
- Write: bytes A5 57 03 5C 08 → `reg_wr_en` pulse with addr 3 and data 0x5C at T+1; tx bytes 0x06; `frame_err`=0.
- Read: bytes A5 52 03 00 51 with `reg_rd_data`=0x5C → tx bytes 0x06 then 0x5C, the second `tx_start` only after `tx_busy` falls.
- Bad checksum and bad address: A5 57 03 5C 00 → NAK, no write, one `frame_err` pulse. A5 57 10 00 47 → NAK, no write.
- Timeout and resync: A5 57, then a TIMEOUT_CYCLES gap → `frame_err` and IDLE, no tx. Then a leading 0x11 is ignored and the following valid write frame succeeds.
- Handshake stall: hold `tx_busy`=1 for 200 cycles at EXEC → `tx_start` stays low and asserts the first cycle after `tx_busy` drops. A byte sent during WAIT1 is dropped.
- Reset mid-frame: assert `reset` after A5 57 03 → all outputs are 0 and there is no write. After release, a full write frame works.
